// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a down-counter that must hold the value w: ceil(log2(w+1)).
    function automatic int cnt_width(input int w);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << n) < 64'(w + 1)) n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Radix-2 sequential multiplier: one multiplier bit per cycle, LSB first,
// signed operands handled as sign + magnitude and re-negated at the end.
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [2*WIDTH:0]    acc;     // {partial sum (WIDTH), multiplier (WIDTH+1)}
    logic [WIDTH:0]      mcand;
    logic                neg;

    logic                smode;
    logic [WIDTH:0]      a_ext, b_ext, a_mag, b_mag;
    logic [WIDTH:0]      sum;
    logic [2*WIDTH:0]    acc_step;
    logic [2*WIDTH-1:0]  mag;

    assign smode = (SIGNED_EN != 0) && signed_mode;

    // Magnitudes in WIDTH+1 bits so -2^(WIDTH-1) negates without overflow.
    always_comb begin
        a_ext = {smode & a[WIDTH-1], a};
        b_ext = {smode & b[WIDTH-1], b};
        a_mag = a_ext[WIDTH] ? (~a_ext + 1'b1) : a_ext;
        b_mag = b_ext[WIDTH] ? (~b_ext + 1'b1) : b_ext;
    end

    // One shift-add step: the partial sum stays below 2^WIDTH after each
    // shift, so WIDTH+1 bits carry the addition without loss. After WIDTH
    // steps the product sits in acc[2*WIDTH:1].
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH:WIDTH+1]} + (acc[0] ? mcand : '0);
        acc_step = {sum, acc[WIDTH:1]};
        mag      = acc[2*WIDTH:1];
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? RUN : IDLE;
            RUN:        if (cnt == '0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, step while counting, publish
    // the signed result on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand <= a_mag;
                        acc   <= {{WIDTH{1'b0}}, b_mag};
                        cnt   <= CW'(WIDTH);
                        neg   <= smode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        acc <= acc_step;
                        cnt <= cnt - 1'b1;
                    end else begin
                        product <= neg ? (~mag + 1'b1) : mag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: an 8-bit signed-capable instance for
// directed/boundary/timing cases and a 16-bit unsigned-only instance for a
// back-to-back random sweep, both against an arithmetic reference model.
module tb_seq_mult;

    logic        clk;
    logic        reset_n;

    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] prod16;

    int checks;
    int errors;

    seq_mult #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    seq_mult #(.WIDTH(16), .SIGNED_EN(0)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .product(prod16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product of the operands as interpreted.
    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b);
        return 32'(longint'(a) * longint'(b));
    endfunction

    // One 8-bit operation starting now (#1 after an edge, DUT in IDLE/DONE).
    // Checks busy on every RUN cycle, done exactly 9 edges after acceptance,
    // and the product. With hold=1 start stays high and operands are
    // scrambled during RUN; the result must still reflect the originals.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input bit hold, input string tag);
        logic [15:0] exp;
        exp    = model8(a, b, s);
        start8 = 1'b1; a8 = a; b8 = b; sm8 = s;
        @(posedge clk); #1;
        chk({tag, " accept busy/done"}, {busy8, done8}, 2'b10);
        if (hold) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~s;
        end else begin
            start8 = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk({tag, " run busy/done"}, {busy8, done8}, 2'b10);
        end
        @(posedge clk); #1;
        chk({tag, " done busy/done"}, {busy8, done8}, 2'b01);
        chk({tag, " product"}, prod8, exp);
    endtask

    initial begin
        logic [15:0] exp16;
        logic [15:0] hold_exp;
        int          cyc;
        bit          saw_done;

        checks = 0; errors = 0;
        reset_n = 1'b0;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        start16 = 0; sm16 = 0; a16 = 0; b16 = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset dut8 busy/done", {busy8, done8}, 2'b00);
        chk("reset dut8 product", prod8, 16'h0);
        chk("reset dut16 busy/done", {busy16, done16}, 2'b00);
        chk("reset dut16 product", prod16, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle after reset", {busy8, done8}, 2'b00);

        // Directed corner products with full latency.
        op8(8'hFF, 8'hFF, 1'b0, 0, "u255x255");
        chk("u255x255 value", prod8, 16'hFE01);
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("back to idle", {busy8, done8}, 2'b00);
        chk("product held in idle", prod8, 16'hFE01);

        op8(8'h80, 8'h80, 1'b1, 0, "s-128x-128");
        chk("s-128x-128 value", prod8, 16'h4000);
        op8(8'hFD, 8'h05, 1'b1, 0, "s-3x5");
        chk("s-3x5 value", prod8, 16'hFFF1);
        op8(8'h00, 8'h80, 1'b1, 0, "s0x-128");
        op8(8'h80, 8'h7F, 1'b1, 0, "s-128x127");
        op8(8'hFF, 8'hFF, 1'b1, 0, "s-1x-1");
        op8(8'h80, 8'hFF, 1'b0, 0, "u128x255");

        // start held high with changing operands during RUN, then a second
        // op accepted straight from DONE.
        op8(8'hC3, 8'h5A, 1'b1, 1, "hold first");
        op8(8'h11, 8'hEE, 1'b0, 0, "hold second");

        // Random back-to-back mixed-mode ops.
        for (int n = 0; n < 40; n++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand8");
        start8 = 1'b0;
        @(posedge clk); #1;
        hold_exp = prod8;

        // Reset mid-RUN aborts immediately; no done pulse afterwards.
        start8 = 1'b1; a8 = 8'h37; b8 = 8'h29; sm8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset busy", busy8, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrun reset busy/done", {busy8, done8}, 2'b00);
        chk("midrun reset product", prod8, 16'h0);
        chk("midrun reset cleared old", (prod8 == hold_exp) && (hold_exp != 16'h0), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) saw_done = 1;
        end
        chk("no activity after abort", saw_done, 1'b0);
        op8(8'h9C, 8'h0B, 1'b1, 0, "after reset");
        start8 = 1'b0;

        // 16-bit unsigned-only sweep, start held through DONE (no idle).
        start16 = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if (n == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
            else if (n == 1) begin a16 = 16'h0000; b16 = 16'h8000; end
            else begin a16 = 16'($urandom); b16 = 16'($urandom); end
            sm16  = 1'($urandom) | (n == 0);
            exp16 = 16'h0;
            @(posedge clk); #1;
            chk("sweep accept busy", busy16, 1'b1);
            begin
                logic [31:0] e;
                e = model16(a16, b16);
                a16 = 16'($urandom); b16 = 16'($urandom);
                cyc = 0;
                while (!done16 && cyc < 40) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                chk("sweep latency", 64'(cyc), 64'd17);
                chk("sweep product", prod16, e);
            end
        end
        start16 = 1'b0;
        @(posedge clk); #1;
        chk("sweep end idle", {busy16, done16}, {1'b0, exp16[0]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 Parameter SIGNED_EN, default 1: when 0, signed_mode is ignored and treated as 0.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a multiply; sampled on rising edge.
REQ-006 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 a  input  WIDTH  multiplicand; sampled with start.
REQ-008 b  input  WIDTH  multiplier; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when product becomes valid.
REQ-011 product  output  2*WIDTH  full-width result, registered, held until next accepted start.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL latch a, b and signed_mode and enter RUN.
REQ-014 In IDLE or DONE, start=0 at an edge SHALL enter or remain in IDLE.
REQ-015 start SHALL be ignored in RUN; operands latched at acceptance SHALL NOT change mid-operation.
REQ-016 RUN SHALL execute radix-2 shift-add: one multiplier bit per cycle, LSB first, for exactly WIDTH cycles, tracked by a down-counter.
REQ-017 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL load WIDTH on acceptance.
REQ-018 When the counter reaches 0, the FSM SHALL enter DONE.
REQ-019 Timing: start accepted at edge k -> busy=1 for edges k+1..k+WIDTH; done=1 and product valid after edge k+WIDTH+1.
REQ-020 busy SHALL be 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-021 Back-to-back operation: start accepted in DONE SHALL begin the new operation with no idle cycle.
REQ-022 Signed mode: operands SHALL be converted to magnitudes at acceptance; the result sign SHALL be sign(a) XOR sign(b).
REQ-023 A negative result SHALL be two's-complement negated when written to product.
REQ-024 Magnitude of the most-negative operand (-2^(WIDTH-1)) SHALL be computed in WIDTH+1 bits so that no overflow occurs.
REQ-025 Unsigned mode SHALL produce the exact unsigned product; no result truncation in either mode.
REQ-026 The accumulator SHALL be 2*WIDTH+1 bits internally.
REQ-027 product SHALL update only on the DONE-entry edge and SHALL hold otherwise.
REQ-028 A zero operand SHALL still take the full WIDTH cycles; there is no early termination.

Reset
REQ-029 While reset_n=0: state=IDLE, busy=0, done=0, product=0, counter=0, accumulator=0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation immediately; no done pulse SHALL follow.
REQ-031 After reset_n deasserts, the first accepted start SHALL behave per REQ-019.

Structure
REQ-032 A shared package mult_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width function.
REQ-033 Unused encoding 2'd3 SHALL return to IDLE.
REQ-034 The block SHALL be a single module; no sub-module is required.
REQ-035 The negate and magnitude logic SHALL be combinational inside seq_mult.

Verification
REQ-036 WIDTH=8, unsigned: a=255, b=255, start 1 cycle -> done exactly 9 edges after acceptance, product=16'hFE01.
REQ-037 WIDTH=8, signed: a=8'h80, b=8'h80 -> product=16'h4000; a=8'hFD(-3), b=5 -> product=16'hFFF1.
REQ-038 WIDTH=8, signed: a=0, b=8'h80 -> product=0 with full 8-cycle latency.
REQ-039 start held high with new operands during RUN -> result reflects the first operands; a second op starts only from DONE.
REQ-040 reset_n pulsed low at RUN cycle 4 -> busy=0, done=0 and product=0 immediately; no done pulse afterwards.
REQ-041 WIDTH=16, SIGNED_EN=0, random 1000-op sweep with start asserted in DONE -> every product matches the reference model; no idle cycles between ops.
